// File: rtl/usr_pkg.sv
// Shared mode encoding for the universal shift register and the logic that drives MODE.
package usr_pkg;

  typedef logic [2:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD = 3'b000;
  localparam usr_mode_t MODE_LOAD = 3'b001;
  localparam usr_mode_t MODE_SHL  = 3'b010;
  localparam usr_mode_t MODE_SHR  = 3'b011;
  localparam usr_mode_t MODE_ROL  = 3'b100;
  localparam usr_mode_t MODE_ROR  = 3'b101;
  localparam usr_mode_t MODE_CLR  = 3'b110;
  localparam usr_mode_t MODE_ASR  = 3'b111;

endpackage

// File: rtl/usr_next_state.sv
// Next-state decode for the universal shift register; purely combinational.
module usr_next_state
  import usr_pkg::*;
#(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] q_i,
  input  usr_mode_t        mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_lsb_i,
  input  logic             sin_msb_i,
  output logic [WIDTH-1:0] q_next_o
);

  // A 1-bit register has no neighbour to shift from: rotates and ASR degenerate to hold.
  if (WIDTH == 1) begin : g_w1
    always_comb begin
      // NOTE: default first so every path assigns q_next_o and no latch is inferred.
      q_next_o = q_i;
      case (mode_i)
        MODE_LOAD: q_next_o = d_i;
        MODE_SHL:  q_next_o = sin_lsb_i;
        MODE_SHR:  q_next_o = sin_msb_i;
        MODE_CLR:  q_next_o = RESET_VALUE;
        default:   q_next_o = q_i;
      endcase
    end
  end else begin : g_wn
    always_comb begin
      q_next_o = q_i;
      case (mode_i)
        MODE_LOAD: q_next_o = d_i;
        MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], sin_lsb_i};
        MODE_SHR:  q_next_o = {sin_msb_i, q_i[WIDTH-1:1]};
        MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
        MODE_CLR:  q_next_o = RESET_VALUE;
        MODE_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        default:   q_next_o = q_i;
      endcase
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with async active-low reset, clock enable,
// eight synchronous modes and true/complement outputs.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             CE,
  input  usr_mode_t        MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN_LSB,
  input  logic             SIN_MSB,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic             SOUT_MSB,
  output logic             SOUT_LSB
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  usr_next_state #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_next_state (
    .q_i       (q_q),
    .mode_i    (MODE),
    .d_i       (D),
    .sin_lsb_i (SIN_LSB),
    .sin_msb_i (SIN_MSB),
    .q_next_o  (q_d)
  );

  // CE gates the whole update, so it also blocks LOAD and the synchronous CLR.
  always_ff @(posedge CLK or negedge RST_n) begin
    // NOTE: non-blocking assignment for flop state avoids simulation ordering races.
    if (!RST_n)  q_q <= RESET_VALUE;
    else if (CE) q_q <= q_d;
  end

  assign Q        = q_q;
  assign Q_n      = ~q_q;
  assign SOUT_MSB = q_q[WIDTH-1];
  assign SOUT_LSB = q_q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=8, RESET_VALUE=0).
module tb_universal_shift_reg;
  import usr_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       ce = 1'b0;
  usr_mode_t  mode = MODE_HOLD;
  logic [7:0] d = 8'h00;
  logic       sin_lsb = 1'b0;
  logic       sin_msb = 1'b0;
  logic [7:0] q, q_n;
  logic       sout_msb, sout_lsb;

  logic       ce_c = 1'b0;
  usr_mode_t  mode_c = MODE_HOLD;
  logic       sin_c = 1'b0;
  logic [7:0] q_lo, q_hi, qn_lo, qn_hi;
  logic       so_lo_msb, so_lo_lsb, so_hi_msb, so_hi_lsb;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) u_dut (
    .CLK(CLK), .RST_n(RST_n), .CE(ce), .MODE(mode), .D(d),
    .SIN_LSB(sin_lsb), .SIN_MSB(sin_msb),
    .Q(q), .Q_n(q_n), .SOUT_MSB(sout_msb), .SOUT_LSB(sout_lsb)
  );

  universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) u_lo (
    .CLK(CLK), .RST_n(RST_n), .CE(ce_c), .MODE(mode_c), .D(8'h00),
    .SIN_LSB(sin_c), .SIN_MSB(1'b0),
    .Q(q_lo), .Q_n(qn_lo), .SOUT_MSB(so_lo_msb), .SOUT_LSB(so_lo_lsb)
  );

  universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) u_hi (
    .CLK(CLK), .RST_n(RST_n), .CE(ce_c), .MODE(mode_c), .D(8'h00),
    .SIN_LSB(so_lo_msb), .SIN_MSB(1'b0),
    .Q(q_hi), .Q_n(qn_hi), .SOUT_MSB(so_hi_msb), .SOUT_LSB(so_hi_lsb)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs just after a falling edge, return at the next falling edge (one rising edge in between).
  task automatic cyc(input logic c, input usr_mode_t m, input logic [7:0] dv,
                     input logic sl, input logic sm);
    ce = c; mode = m; d = dv; sin_lsb = sl; sin_msb = sm;
    @(negedge CLK);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pat;
    logic [7:0]  rol_exp [8];
    rol_exp = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0};

    // Power-on reset with an edge inside it.
    @(negedge CLK);
    cyc(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
    check("por_q", {8'h00, q}, 16'h0000);
    check("por_qn", {8'h00, q_n}, 16'h00FF);
    RST_n = 1'b1;

    // Mid-cycle async reset from A5.
    cyc(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
    check("load_a5", {8'h00, q}, 16'h00A5);
    ce = 1'b0;
    #2 RST_n = 1'b0;
    #1;
    check("rst_mid_q", {8'h00, q}, 16'h0000);
    check("rst_mid_qn", {8'h00, q_n}, 16'h00FF);
    @(negedge CLK);
    cyc(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
    check("rst_edges_q", {8'h00, q}, 16'h0000);
    RST_n = 1'b1;

    // Load, CE=0 overriding CLR, then hold.
    cyc(1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
    check("load_3c", {8'h00, q}, 16'h003C);
    check("load_3c_qn", {8'h00, q_n}, 16'h00C3);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, MODE_CLR, 8'h00, 1'b0, 1'b0);
      check("ce0_clr", {8'h00, q}, 16'h003C);
    end
    cyc(1'b0, MODE_LOAD, 8'hEE, 1'b1, 1'b1);
    check("ce0_load", {8'h00, q}, 16'h003C);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, MODE_HOLD, 8'hEE, 1'b1, 1'b1);
      check("hold", {8'h00, q}, 16'h003C);
    end

    // Shifts.
    cyc(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
    check("sout_msb_81", {15'h0, sout_msb}, 16'h0001);
    check("sout_lsb_81", {15'h0, sout_lsb}, 16'h0001);
    cyc(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b1);
    check("shl", {8'h00, q}, 16'h0003);
    check("sout_msb_03", {15'h0, sout_msb}, 16'h0000);
    cyc(1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
    check("shr", {8'h00, q}, 16'h0001);
    cyc(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
    check("shr_sin1", {8'h00, q}, 16'h0080);
    cyc(1'b1, MODE_LOAD, 8'h90, 1'b0, 1'b0);
    cyc(1'b1, MODE_ASR, 8'h00, 1'b0, 1'b0);
    check("asr", {8'h00, q}, 16'h00C8);
    cyc(1'b1, MODE_ASR, 8'h00, 1'b0, 1'b0);
    check("asr2", {8'h00, q}, 16'h00E4);

    // Rotates.
    cyc(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
    cyc(1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
    check("rol", {8'h00, q}, 16'h0003);
    cyc(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
    check("ror1", {8'h00, q}, 16'h0081);
    cyc(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
    check("ror2", {8'h00, q}, 16'h00C0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, MODE_ROL, 8'h00, 1'b1, 1'b1);
      check("rol8", {8'h00, q}, {8'h00, rol_exp[i]});
    end

    // Synchronous clear lands only on the edge.
    cyc(1'b1, MODE_LOAD, 8'h77, 1'b0, 1'b0);
    ce = 1'b1; mode = MODE_CLR;
    #1;
    check("clr_pre_edge", {8'h00, q}, 16'h0077);
    @(negedge CLK);
    check("clr_edge", {8'h00, q}, 16'h0000);

    // Reset pulse between edges, then the first LOAD after release.
    cyc(1'b1, MODE_LOAD, 8'h66, 1'b0, 1'b0);
    ce = 1'b0;
    #1 RST_n = 1'b0;
    #1;
    check("rst_pulse", {8'h00, q}, 16'h0000);
    RST_n = 1'b1;
    ce = 1'b1; mode = MODE_LOAD; d = 8'h5A;
    #1;
    check("post_rel_pre", {8'h00, q}, 16'h0000);
    @(negedge CLK);
    check("post_rel_load", {8'h00, q}, 16'h005A);

    // Two-stage serial chain, 16'hBEEF shifted in MSB first.
    ce = 1'b0;
    pat = 16'hBEEF;
    check("chain_init", {q_hi, q_lo}, 16'h0000);
    ce_c = 1'b1; mode_c = MODE_SHL;
    for (int i = 15; i >= 0; i--) begin
      sin_c = pat[i];
      @(negedge CLK);
      if (i == 1) check("chain_15", {q_hi, q_lo}, 16'h5F77);
    end
    ce_c = 1'b0;
    check("chain_16", {q_hi, q_lo}, 16'hBEEF);
    @(negedge CLK);
    check("chain_hold", {q_hi, q_lo}, 16'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register: a WIDTH-bit bank of D flip-flops with an asynchronous active-low reset, a clock enable, and eight synchronous modes (hold, parallel load, logical and arithmetic shifts, rotates, synchronous clear). It generalises the single-bit asynchronous-reset D flip-flop in this codebase into a multi-bit, multi-mode register. It provides true and complement outputs, in the same pattern as the single-bit part. Downstream users are serial/parallel converters and counter-style datapaths in the lab designs.

## Interface
Parameters:
- WIDTH, 8: register width in bits; legal range ≥ 1.
- RESET_VALUE, {WIDTH{1'b0}}: value Q takes while RST_n is low.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_n  input  1  reset; asynchronous, active-low.
- CE  input  1  clock enable; when 0, the register holds regardless of MODE.
- MODE  input  3  operation select, decoded below.
- D  input  WIDTH  parallel load data.
- SIN_LSB  input  1  serial bit shifted into bit 0 on shift-left.
- SIN_MSB  input  1  serial bit shifted into bit WIDTH-1 on shift-right.
- Q  output  WIDTH  register contents.
- Q_n  output  WIDTH  bitwise complement of Q, always equal to ~Q.
- SOUT_MSB  output  1  Q[WIDTH-1]; serial out for shift-left chains.
- SOUT_LSB  output  1  Q[0]; serial out for shift-right chains.

## Operation
- RST_n low: Q = RESET_VALUE immediately, independent of CLK. Q_n = ~RESET_VALUE. This holds for as long as RST_n is low.
- On a rising CLK edge with RST_n high and CE = 1, MODE selects the action:
  - 000 HOLD: Q unchanged.
  - 001 LOAD: Q ← D.
  - 010 SHL: Q ← {Q[W-2:0], SIN_LSB}.
  - 011 SHR: Q ← {SIN_MSB, Q[W-1:1]}.
  - 100 ROL: Q ← {Q[W-2:0], Q[W-1]}.
  - 101 ROR: Q ← {Q[0], Q[W-1:1]}.
  - 110 CLR: Q ← RESET_VALUE (synchronous).
  - 111 ASR: Q ← {Q[W-1], Q[W-1:1]}.
- CE = 0 overrides every MODE, including CLR and LOAD.
- WIDTH = 1: SHL gives Q ← SIN_LSB. SHR gives Q ← SIN_MSB. ROL, ROR and ASR leave Q unchanged.
- Q_n, SOUT_MSB and SOUT_LSB are purely combinational from the Q flops. No extra register stage.
- No X propagation from unused serial inputs. SIN_* are sampled only in SHL and SHR respectively.

## Timing
- Latency is 1 cycle: the new Q is visible after the capturing rising edge and is stable for the whole following cycle.
- Reset assertion takes effect within propagation delay, mid-cycle if needed. A rising edge during reset is ignored.
- Reset release is asynchronous. The first state change happens on the first rising edge after RST_n rises, provided setup time is met. If RST_n and the CLK edge coincide, either outcome is acceptable; the bench must not test that race.
- Serial chaining: SOUT_MSB of stage k → SIN_LSB of stage k+1. The result is an exact 2·WIDTH-bit shift with no bubble.
- Mode changes are accepted every cycle. There is no back-pressure and no handshake.

## Structure
- Package usr_pkg: 3-bit mode localparams (MODE_HOLD … MODE_ASR) and a mode typedef, shared with users that drive MODE.
- Sub-module usr_next_state: combinational function of (Q, MODE, D, SIN_LSB, SIN_MSB, RESET_VALUE) returning the next Q. WIDTH=1 special-casing lives here.
- Top: a single always block sensitive to posedge CLK or negedge RST_n, gated by CE. Output assigns sit alongside it.

## Test plan
All checks use WIDTH=8 and RESET_VALUE=8'h00.
- Reset: RST_n=0 mid-cycle with Q=8'hA5 → Q=8'h00 and Q_n=8'hFF before the next edge. Edges during reset leave Q at 8'h00.
- Load/hold/CE: LOAD D=8'h3C → Q=8'h3C. Then CE=0 with MODE=CLR for 3 edges → Q stays 8'h3C. Then HOLD for 2 edges → Q stays 8'h3C.
- Shifts: Q=8'h81.
  - SHL with SIN_LSB=1 → 8'h03.
  - SHR with SIN_MSB=0 → 8'h01.
  - ASR from 8'h90 → 8'hC8.
- Rotates: Q=8'h81. ROL → 8'h03. ROR ×2 → 8'hC0. 8 consecutive ROLs return the original value.
- Serial chain: two instances chained, shifting in 16 bits of 16'hBEEF MSB-first → {Q_hi,Q_lo}=16'hBEEF after exactly 16 edges.
- Sync clear vs async reset: CLR with CE=1 → Q=8'h00 only at the edge. RST_n pulse between edges clears immediately. The first post-release LOAD of 8'h5A lands on the next edge.
